// File: rtl/mdu_iter.sv
// mdu_iter -- iterative RV32M multiply/divide unit with regfile writeback.
//
// Accepts one M-extension operation at a time. It computes with a 1-bit-per-cycle
// shift-add multiplier or a restoring divider over 32 iterations, then holds the
// result on the regfile write port until that port is granted.
//
// Handshake: an operation is accepted on a rising edge where I_valid=1, O_ready=1
// and I_flush=0. The write is offered while O_rd_we=1. It commits on the rising
// edge where O_rd_we=1 and I_wb_ready=1. Outputs stay stable until that edge.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   I_valid / O_ready   operation request / unit idle and able to accept
//   I_funct3            M-extension funct3 (MUL..REMU)
//   I_rs1_data/rs2_data operands a and b
//   I_rd_waddr          destination register
//   I_flush             kill the in-flight operation (no write is produced)
//   O_busy, O_busy_rd   hazard info: unit occupied, latched rd (0 when idle)
//   O_rd_we/waddr/wdata regfile write port
//   I_wb_ready          regfile write port granted this cycle
//   O_dbg_state         current FSM state (0 IDLE, 1 CALC, 2 DONE)
module mdu_iter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_valid,
    output logic              O_ready,
    input  logic [2:0]        I_funct3,
    input  logic [XLEN-1:0]   I_rs1_data,
    input  logic [XLEN-1:0]   I_rs2_data,
    input  logic [REG_AW-1:0] I_rd_waddr,
    input  logic              I_flush,
    output logic              O_busy,
    output logic [REG_AW-1:0] O_busy_rd,
    output logic              O_rd_we,
    output logic [REG_AW-1:0] O_rd_waddr,
    output logic [XLEN-1:0]   O_rd_wdata,
    input  logic              I_wb_ready,
    output logic [1:0]        O_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [63:0]       acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quo}
    logic [31:0]       b_q, b_d;         // mul: multiplicand; div: divisor
    logic              sign_a_q, sign_a_d;
    logic              neg_q, neg_d;     // sign(a) ^ sign(b) after signedness
    logic [XLEN-1:0]   wdata_q, wdata_d;

    // Operand decode at acceptance time.
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_by_zero, div_ovf, special;
    logic [31:0] special_res;

    always_comb begin
        // Unsigned operands: MULHU (011), DIVU (101), REMU (111); MULHSU has unsigned b.
        a_signed    = (I_funct3 != 3'b011) && (I_funct3 != 3'b101) && (I_funct3 != 3'b111);
        b_signed    = a_signed && (I_funct3 != 3'b010);
        a_neg       = a_signed & I_rs1_data[31];
        b_neg       = b_signed & I_rs2_data[31];
        a_mag       = a_neg ? (32'd0 - I_rs1_data) : I_rs1_data;
        b_mag       = b_neg ? (32'd0 - I_rs2_data) : I_rs2_data;
        div_by_zero = I_funct3[2] && (I_rs2_data == 32'd0);
        // Signed divide ops (DIV 100, REM 110) have funct3[0] clear.
        div_ovf     = I_funct3[2] && !I_funct3[0] &&
                      (I_rs1_data == 32'h8000_0000) && (I_rs2_data == 32'hFFFF_FFFF);
        special     = div_by_zero || div_ovf;
        special_res = 32'd0;
        if (div_by_zero) begin
            special_res = I_funct3[1] ? I_rs1_data : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = I_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of the datapath, shared by both algorithms.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [64:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_step;
    logic [63:0] step;
    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic [31:0] final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, b_q};
        // The carry out of the add becomes bit 63 after the right shift.
        mul_step  = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        div_shift = {acc_q, 1'b0};
        div_trial = div_shift[64:32] - {1'b0, b_q};
        // On a failed trial the shifted remainder is below the divisor, so its top bit is 0.
        div_step  = div_trial[32] ? div_shift[63:0]
                                  : {div_trial[31:0], div_shift[31:1], 1'b1};
        step      = f3_q[2] ? div_step : mul_step;
        prod      = neg_q ? (64'd0 - step) : step;
        quo       = neg_q ? (32'd0 - step[31:0]) : step[31:0];
        rem       = sign_a_q ? (32'd0 - step[63:32]) : step[63:32];
        case (f3_q)
            3'b000:                  final_res = prod[31:0];
            3'b001, 3'b010, 3'b011:  final_res = prod[63:32];
            3'b100, 3'b101:          final_res = quo;
            default:                 final_res = rem;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (I_valid && !I_flush) begin
                    f3_d     = I_funct3;
                    rd_d     = I_rd_waddr;
                    cnt_d    = 6'd0;
                    acc_d    = {32'd0, (I_funct3[2] ? a_mag : b_mag)};
                    b_d      = I_funct3[2] ? b_mag : a_mag;
                    sign_a_d = a_neg;
                    neg_d    = a_neg ^ b_neg;
                    if (special) begin
                        wdata_d = special_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (I_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        wdata_d = final_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Flush and grant both leave DONE; flush just suppresses O_rd_we.
                if (I_flush || I_wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            f3_q     <= 3'd0;
            rd_q     <= '0;
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            wdata_q  <= wdata_d;
        end
    end

    assign O_ready     = (state_q == S_IDLE);
    assign O_busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign O_busy_rd   = O_busy ? rd_q : '0;
    assign O_rd_we     = (state_q == S_DONE) && !I_flush;
    assign O_rd_waddr  = rd_q;
    assign O_rd_wdata  = wdata_q;
    assign O_dbg_state = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter. Inputs change on the falling edge
// and outputs are sampled on the falling edge (or #1 after an input change).
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_valid;
    logic        O_ready;
    logic [2:0]  I_funct3;
    logic [31:0] I_rs1_data;
    logic [31:0] I_rs2_data;
    logic [4:0]  I_rd_waddr;
    logic        I_flush;
    logic        O_busy;
    logic [4:0]  O_busy_rd;
    logic        O_rd_we;
    logic [4:0]  O_rd_waddr;
    logic [31:0] O_rd_wdata;
    logic        I_wb_ready;
    logic [1:0]  O_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .I_valid    (I_valid),
        .O_ready    (O_ready),
        .I_funct3   (I_funct3),
        .I_rs1_data (I_rs1_data),
        .I_rs2_data (I_rs2_data),
        .I_rd_waddr (I_rd_waddr),
        .I_flush    (I_flush),
        .O_busy     (O_busy),
        .O_busy_rd  (O_busy_rd),
        .O_rd_we    (O_rd_we),
        .O_rd_waddr (O_rd_waddr),
        .O_rd_wdata (O_rd_wdata),
        .I_wb_ready (I_wb_ready),
        .O_dbg_state(O_dbg_state)
    );

    // Issue one op with I_wb_ready=1 and check latency, result, rd and release.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input string name);
        int cyc;
        @(negedge clk);
        n_cmp++;
        if (O_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_before: got %b want 1", name, O_ready);
        end
        I_valid = 1'b1; I_funct3 = f3; I_rs1_data = a; I_rs2_data = b;
        I_rd_waddr = rd; I_wb_ready = 1'b1;
        @(negedge clk);
        // Scramble the operand inputs so the unit must rely on its latched copies.
        I_valid = 1'b0; I_rs1_data = $urandom; I_rs2_data = $urandom;
        I_rd_waddr = 5'($urandom_range(31, 0)); I_funct3 = 3'($urandom_range(7, 0));
        cyc = 1;
        n_cmp++;
        if (O_busy !== 1'b1 || O_busy_rd !== rd) begin
            n_err++; $display("FAIL %s busy: got busy=%b rd=%0d want 1 rd=%0d", name, O_busy, O_busy_rd, rd);
        end
        while (O_rd_we !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        n_cmp++;
        if (O_rd_wdata !== exp) begin
            n_err++; $display("FAIL %s wdata: got %h want %h", name, O_rd_wdata, exp);
        end
        n_cmp++;
        if (O_rd_waddr !== rd) begin
            n_err++; $display("FAIL %s waddr: got %0d want %0d", name, O_rd_waddr, rd);
        end
        @(negedge clk);
        n_cmp++;
        if (O_rd_we !== 1'b0 || O_ready !== 1'b1 || O_busy !== 1'b0) begin
            n_err++; $display("FAIL %s release: got we=%b ready=%b busy=%b want 0 1 0", name, O_rd_we, O_ready, O_busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (O_ready !== 1'b1 || O_busy !== 1'b0 || O_rd_we !== 1'b0 || O_dbg_state !== 2'd0) begin
            n_err++; $display("FAIL %s ctrl: got ready=%b busy=%b we=%b st=%0d want 1 0 0 0", name, O_ready, O_busy, O_rd_we, O_dbg_state);
        end
        n_cmp++;
        if (O_rd_wdata !== 32'd0 || O_rd_waddr !== 5'd0 || O_busy_rd !== 5'd0) begin
            n_err++; $display("FAIL %s data: got wdata=%h waddr=%0d busy_rd=%0d want 0 0 0", name, O_rd_wdata, O_rd_waddr, O_busy_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; I_valid = 1'b0; I_funct3 = 3'd0; I_rs1_data = 32'd0; I_rs2_data = 32'd0;
        I_rd_waddr = 5'd0; I_flush = 1'b0; I_wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, "mul");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, "mulh");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, "mulhsu");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, "div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, "rem");
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h7FFF_FFFC, 33, "divu");
        run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'd1, 33, "remu");
    endtask

    task automatic test_special();
        run_op(3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, "div_by_zero");
        run_op(3'b111, 32'd5, 32'd0, 5'd15, 32'd5, 1, "remu_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, "rem_ovf");
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        I_valid = 1'b1; I_funct3 = 3'b011; I_rs1_data = 32'hFFFF_FFFF; I_rs2_data = 32'hFFFF_FFFF;
        I_rd_waddr = 5'd9; I_wb_ready = 1'b0;
        @(negedge clk);
        I_valid = 1'b0;
        cyc = 1;
        while (O_rd_we !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 33) begin
            n_err++; $display("FAIL bp_latency: got %0d want 33", cyc);
        end
        // Hold DONE for 5 cycles while offering a competing op.
        I_valid = 1'b1; I_funct3 = 3'b000; I_rs1_data = 32'd1; I_rs2_data = 32'd1; I_rd_waddr = 5'd20;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (O_rd_we !== 1'b1 || O_rd_wdata !== 32'hFFFF_FFFE || O_rd_waddr !== 5'd9 || O_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got we=%b wdata=%h waddr=%0d ready=%b want 1 fffffffe 9 0", i, O_rd_we, O_rd_wdata, O_rd_waddr, O_ready);
            end
            @(negedge clk);
        end
        I_valid = 1'b0; I_wb_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (O_rd_we !== 1'b0 || O_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_commit: got we=%b ready=%b want 0 1", O_rd_we, O_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (O_busy !== 1'b0 || O_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_no_queue: got busy=%b ready=%b want 0 1", O_busy, O_ready);
        end
    endtask

    task automatic test_flush_calc();
        logic seen_we;
        @(negedge clk);
        I_valid = 1'b1; I_funct3 = 3'b000; I_rs1_data = 32'd9; I_rs2_data = 32'd9;
        I_rd_waddr = 5'd21; I_wb_ready = 1'b1;
        @(negedge clk);
        I_valid = 1'b0;
        repeat (9) @(negedge clk);
        I_flush = 1'b1;
        #1;
        n_cmp++;
        if (O_rd_we !== 1'b0 || O_dbg_state !== 2'd1) begin
            n_err++; $display("FAIL flush_calc_state: got we=%b st=%0d want 0 1", O_rd_we, O_dbg_state);
        end
        @(negedge clk);
        I_flush = 1'b0;
        n_cmp++;
        if (O_ready !== 1'b1 || O_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_calc_idle: got ready=%b busy=%b want 1 0", O_ready, O_busy);
        end
        seen_we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (O_rd_we === 1'b1) seen_we = 1'b1;
        end
        n_cmp++;
        if (seen_we !== 1'b0) begin
            n_err++; $display("FAIL flush_calc_nowrite: got we seen=%b want 0", seen_we);
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        I_valid = 1'b1; I_flush = 1'b1; I_funct3 = 3'b000; I_rs1_data = 32'd2; I_rs2_data = 32'd2;
        I_rd_waddr = 5'd22;
        @(negedge clk);
        I_valid = 1'b0; I_flush = 1'b0;
        n_cmp++;
        if (O_ready !== 1'b1 || O_busy !== 1'b0 || O_dbg_state !== 2'd0) begin
            n_err++; $display("FAIL flush_idle: got ready=%b busy=%b st=%0d want 1 0 0", O_ready, O_busy, O_dbg_state);
        end
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        I_valid = 1'b1; I_funct3 = 3'b100; I_rs1_data = 32'd5; I_rs2_data = 32'd0;
        I_rd_waddr = 5'd3; I_wb_ready = 1'b0;
        @(negedge clk);
        I_valid = 1'b0;
        n_cmp++;
        if (O_rd_we !== 1'b1) begin
            n_err++; $display("FAIL flush_done_pre: got we=%b want 1", O_rd_we);
        end
        I_flush = 1'b1; I_wb_ready = 1'b1;
        #1;
        n_cmp++;
        if (O_rd_we !== 1'b0) begin
            n_err++; $display("FAIL flush_done_gate: got we=%b want 0", O_rd_we);
        end
        @(negedge clk);
        I_flush = 1'b0;
        n_cmp++;
        if (O_ready !== 1'b1 || O_rd_we !== 1'b0 || O_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_done_idle: got ready=%b we=%b busy=%b want 1 0 0", O_ready, O_rd_we, O_busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        I_valid = 1'b1; I_funct3 = 3'b101; I_rs1_data = 32'd100; I_rs2_data = 32'd7;
        I_rd_waddr = 5'd7; I_wb_ready = 1'b1;
        @(negedge clk);
        I_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_mid");
        run_op(3'b000, 32'd3, 32'd4, 5'd4, 32'd12, 33, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush_calc();
        test_flush_idle();
        test_flush_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit producing register writeback for `regfile`. Accepts one M-extension operation from execute, computes with a 1-bit-per-cycle shift-add multiplier or restoring divider, and drives the regfile write port (`I_rd_we/I_rd_waddr/I_rd_wdata`) through a ready-gated writeback handshake. It holds one operation at a time and exposes busy/rd information for hazard stalling.

## Interface
- `XLEN`, 32, operand/result width. Only 32 is supported.
- `REG_AW`, 5, register address width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `I_valid`  in  1  operation request.
- `O_ready`  out  1  unit idle and able to accept. Equals (state==IDLE).
- `I_funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `I_rs1_data`  in  XLEN  operand a.
- `I_rs2_data`  in  XLEN  operand b.
- `I_rd_waddr`  in  REG_AW  destination register.
- `I_flush`  in  1  kill the in-flight operation.
- `O_busy`  out  1  state is CALC or DONE.
- `O_busy_rd`  out  REG_AW  latched rd. Zero when idle.
- `O_rd_we`  out  1  write request. Equals (state==DONE) & ~I_flush.
- `O_rd_waddr`  out  REG_AW  latched rd.
- `O_rd_wdata`  out  XLEN  result register.
- `I_wb_ready`  in  1  regfile port granted this cycle.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - Accept on I_valid & ~I_flush.
  - Latch funct3, rd, operand magnitudes, sign flags, and the negate-result flag.
  - Clear the 6-bit counter.
  - Go to CALC, except for the special cases below.
- **Special cases** go IDLE→DONE directly with the result loaded:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow: DIV with rs1=0x80000000 and rs2=0xFFFFFFFF gives 0x80000000; REM gives 0.
- **Signedness**
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
  - Magnitudes are taken with two's-complement negate.
- **Multiply**
  - 64-bit accumulator, 32 iterations.
  - Each iteration: if multiplier LSB is set, add the multiplicand into the upper half; then shift right 1.
  - Final result is negated (64-bit) when the operand signs differ.
  - MUL returns bits [31:0]; the MULH variants return [63:32].
- **Divide**
  - Restoring, 32 iterations.
  - Each iteration: shift {rem, quo} left 1; trial-subtract the divisor from the 33-bit remainder; keep the difference and set the quotient LSB when non-negative.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- **CALC**
  - Counter increments each cycle.
  - After the 32nd iteration edge: write the sign-corrected result to O_rd_wdata and go to DONE.
- **DONE**
  - O_rd_we high (unless I_flush).
  - O_rd_waddr and O_rd_wdata held stable.
  - Go to IDLE on the edge where I_wb_ready=1.
- **rd = 0**
  - Operation completes normally.
  - regfile discards the write.
- **Flush**
  - I_flush in any state → IDLE at the next edge; no write is produced.
  - In DONE, flush gates O_rd_we combinationally in the same cycle.
  - Flush beats a same-cycle I_valid.
  - Flush beats a same-cycle I_wb_ready.
- **Reset**
  - rst has priority over everything and may arrive mid-operation.
  - Next edge: state IDLE; counter, O_rd_wdata, O_rd_waddr and O_busy_rd are 0.
  - After reset: O_ready=1, O_busy=0, O_rd_we=0.

## Timing
- Acceptance edge = E0. Normal ops:
  - CALC during cycles E0+1 … E0+32.
  - DONE and O_rd_we visible from E0+33 (33-cycle latency).
- Special cases: O_rd_we visible the cycle after E0 (1-cycle latency).
- Writeback:
  - If I_wb_ready=1 in the first DONE cycle, the write commits on that edge.
  - O_ready rises the following cycle.
  - Next accept is possible on the edge after that, giving 34-cycle throughput for normal ops.
- Backpressure: DONE persists indefinitely with outputs stable until granted.
- O_ready is low for the whole of CALC and DONE; I_valid is ignored then, with no queueing.
- O_busy and O_busy_rd are valid from E0+1 until the cycle after the writeback edge.

## Test plan
- **MUL:** MUL 7 × 0xFFFFFFFD, rd=5, I_wb_ready=1 → O_rd_we at E0+33 with wdata=0xFFFFFFEB and waddr=5, one cycle only; O_ready=1 next cycle.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
  - All at 33-cycle latency.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All at 1-cycle latency.
- **Backpressure:** I_wb_ready=0 for 5 DONE cycles → O_rd_we, wdata and waddr stable, O_ready=0, I_valid ignored; raise I_wb_ready → single commit, then IDLE.
- **Flush and reset:**
  - I_flush at CALC cycle 10 → no O_rd_we; O_ready=1 next cycle.
  - I_flush with I_valid in IDLE → not accepted.
  - I_flush with I_wb_ready in DONE → O_rd_we=0.
  - rst mid-CALC → all outputs at reset values next cycle.
  - A new MUL 3×4 afterwards → 12.
